ladybird_fetch_queue: RTL
=========================

# ladybird_fetch_queue

Instruction fetch front-end sitting directly upstream of the core's decode/execute stage. It generates sequential fetch addresses, issues them to the MMU instruction port with a valid/ready handshake, and buffers returned instruction words with their PCs in a small in-order FIFO. It also handles redirects: a taken branch, a jump or the initial start flushes the queue and drops stale in-flight responses.

## Interface
- XLEN, 32, data/address width
- DEPTH, 4, FIFO entries and max in-flight requests (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc (start or commit-stage branch)
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0)
- mem_req_valid  out  1  fetch request to MMU instruction port
- mem_req_ready  in  1  MMU accepts request
- mem_req_addr  out  XLEN  fetch address, word aligned
- mem_rsp_valid  in  1  instruction return, one per accepted request, in order, ≥1 cycle after acceptance
- mem_rsp_data  in  XLEN  instruction word
- inst_valid  out  1  head entry valid to decode
- inst_ready  in  1  decode consumes head entry
- inst_pc  out  XLEN  PC of head entry
- inst_data  out  XLEN  instruction of head entry
- idle  out  1  no request pending, FIFO empty, not running

## Operation
- States: IDLE (after reset, no fetching) and RUN. IDLE→RUN on redirect_valid. There is no RUN→IDLE transition except rst.
- fetch_pc register (reset 0). On redirect_valid: fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}. Otherwise, on a request handshake: fetch_pc ← fetch_pc+4, wrapping modulo 2^XLEN.
- mem_req_valid = RUN & ~redirect_valid & (fifo_count + outstanding < DEPTH). mem_req_addr = fetch_pc.
- outstanding: counter of accepted requests with no response yet, width $clog2(DEPTH+1). +1 on handshake, −1 on mem_rsp_valid, both in one cycle → unchanged.
- discard: counter, same width. On redirect_valid: discard ← outstanding − (mem_rsp_valid?1:0). While discard>0, each mem_rsp_valid decrements discard and the data is dropped.
- PC tagging: a pc_tag FIFO (DEPTH entries) records mem_req_addr at handshake and pops on response, whether the response is kept or discarded. It is cleared on redirect. Entries after a flush are realigned by discard: kept responses pop tags pushed after the redirect only. The implementation stores tags only for post-redirect requests and counts discards separately.
- Data FIFO: a kept response pushes {tag_pc, mem_rsp_data}. The head is driven on inst_pc/inst_data, and inst_valid = fifo_count≠0. Pop on inst_valid & inst_ready.
- Overflow is impossible by construction. A response arriving with outstanding=0 is a protocol error and is ignored.
- redirect_valid has priority over every other event in the same cycle: FIFO and tag FIFO are cleared, any pop is void, and any mem_rsp that cycle is dropped.
- idle = IDLE state, or (RUN with outstanding=0 & fifo_count=0 & ~mem_req_valid). The latter case is not reachable in normal RUN.

## Timing
- Reset values: mem_req_valid 0, mem_req_addr 0, inst_valid 0, inst_pc 0, inst_data 0, idle 1, all counters 0, state IDLE.
- redirect at cycle N: mem_req_valid=1 with the new address at N+1. inst_valid is 0 from N+1 until the first kept response is registered.
- Response at cycle M → inst_valid at M+1 (registered FIFO, no bypass). Minimum redirect-to-inst_valid latency is 3 cycles with a 1-cycle memory.
- Push and pop in the same cycle while full or nonempty: count unchanged, order preserved.
- Sustained throughput is 1 instruction/cycle when mem latency + 1 ≤ DEPTH and decode is always ready.
- A request handshake in the same cycle as redirect cannot occur, because mem_req_valid is gated by redirect_valid.
- rst mid-operation returns everything to reset values next cycle. Responses to pre-reset requests are then ignored because outstanding=0.

## Test plan
- Reset, then redirect_pc=0x1000, 1-cycle memory returning addr^0xA5A5A5A5, inst_ready=1 → inst_pc 0x1000,0x1004,0x1008… each with matching data, one per cycle after a 3-cycle startup.
- inst_ready=0 after redirect to 0x200 → exactly DEPTH=4 requests issued (0x200–0x20C), then mem_req_valid stays 0. Raising inst_ready resumes with 0x210.
- 3 requests in flight (memory latency 3) with redirect to 0x8000 → the 3 stale responses are dropped, and the first inst_pc is 0x8000 with the correct data.
- Redirect in the same cycle as a response and an inst pop → the response is dropped, the FIFO is empty next cycle, and discard = outstanding−1.
- redirect_pc=0xFFFFFFFE → address 0xFFFFFFFC, then wraps to 0x00000000, 0x00000004.
- Assert rst with FIFO full and 2 in flight → next cycle all outputs are at reset values and idle=1. Late responses produce no inst_valid.

Source files
------------

// File: rtl/ladybird_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, MMU instruction request/response
// channel and the decode-side instruction handshake.
interface ladybird_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic            idle;

  // Fetch-queue side
  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data, idle
  );

  // Environment side: core control, MMU and decode
  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_pc, inst_data, idle
  );
endinterface

// File: rtl/ladybird_fetch_queue.sv
// Instruction fetch front-end: sequential fetch address generation, in-order
// response buffering with PC tags, and redirect flush with stale-response discard.
module ladybird_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ladybird_fetch_queue_if.master   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   outstanding_r, discard_r, fifo_count_r;
  logic [CW-1:0]   outstanding_nxt_s;
  logic [AW-1:0]   fifo_wptr_r, fifo_rptr_r, tag_wptr_r, tag_rptr_r;
  logic [XLEN-1:0] fifo_pc_r   [DEPTH];
  logic [XLEN-1:0] fifo_data_r [DEPTH];
  logic [XLEN-1:0] tag_pc_r    [DEPTH];

  logic            req_valid_s, req_hs_s, room_s;
  logic            rsp_live_s, rsp_keep_s, rsp_drop_s, pop_s;
  logic [CW:0]     occupancy_s;

  // Event decode; a redirect voids every push/pop in its cycle
  always_comb begin
    occupancy_s = {1'b0, fifo_count_r} + {1'b0, outstanding_r};
    room_s      = (occupancy_s < DEPTH_W);
    req_hs_s    = req_valid_s & bus.mem_req_ready;
    rsp_live_s  = bus.mem_rsp_valid & (outstanding_r != '0);
    rsp_keep_s  = rsp_live_s & (discard_r == '0) & ~bus.redirect_valid;
    rsp_drop_s  = rsp_live_s & (discard_r != '0) & ~bus.redirect_valid;
    pop_s       = (fifo_count_r != '0) & bus.inst_ready & ~bus.redirect_valid;
    if (req_hs_s && !rsp_live_s) begin
      outstanding_nxt_s = outstanding_r + CW'(1);
    end else if (rsp_live_s && !req_hs_s) begin
      outstanding_nxt_s = outstanding_r - CW'(1);
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
  end

  // Next state and request/idle outputs
  always_comb begin
    state_nxt_s = state_r;
    req_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.redirect_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        req_valid_s = ~bus.redirect_valid & room_s;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, in-flight accounting and discard of pre-redirect responses
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      if (bus.redirect_valid) begin
        fetch_pc_r <= bus.redirect_pc & ~XLEN'(3);
        discard_r  <= outstanding_nxt_s;
      end else begin
        if (req_hs_s) begin
          fetch_pc_r <= fetch_pc_r + XLEN'(4);
        end
        if (rsp_drop_s) begin
          discard_r <= discard_r - CW'(1);
        end
      end
    end
  end

  // PC tag FIFO for post-redirect requests, and the instruction FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wptr_r   <= '0;
      tag_rptr_r   <= '0;
      fifo_wptr_r  <= '0;
      fifo_rptr_r  <= '0;
      fifo_count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc_r[i]    <= '0;
        fifo_pc_r[i]   <= '0;
        fifo_data_r[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      tag_wptr_r   <= '0;
      tag_rptr_r   <= '0;
      fifo_wptr_r  <= '0;
      fifo_rptr_r  <= '0;
      fifo_count_r <= '0;
    end else begin
      if (req_hs_s) begin
        tag_pc_r[tag_wptr_r] <= fetch_pc_r;
        tag_wptr_r           <= tag_wptr_r + AW'(1);
      end
      if (rsp_keep_s) begin
        fifo_pc_r[fifo_wptr_r]   <= tag_pc_r[tag_rptr_r];
        fifo_data_r[fifo_wptr_r] <= bus.mem_rsp_data;
        fifo_wptr_r              <= fifo_wptr_r + AW'(1);
        tag_rptr_r               <= tag_rptr_r + AW'(1);
      end
      if (pop_s) begin
        fifo_rptr_r <= fifo_rptr_r + AW'(1);
      end
      case ({rsp_keep_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_s;
  assign bus.mem_req_addr  = fetch_pc_r;
  assign bus.inst_valid    = (fifo_count_r != '0);
  assign bus.inst_pc       = fifo_pc_r[fifo_rptr_r];
  assign bus.inst_data     = fifo_data_r[fifo_rptr_r];
  assign bus.idle          = (state_r == ST_IDLE) |
                             ((outstanding_r == '0) & (fifo_count_r == '0) & ~req_valid_s);
endmodule
